// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and the main control decoder:
// FSM state encoding, MIPS opcode constants and the default reset PC.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_next_pc_sel.sv
// next_pc_sel: combinational next-PC select for jump, taken branch or fall-through.
module next_pc_sel
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        unused_op;

    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign unused_op     = ^instr[31:26];

    // Jump outranks branch when the decoder raises both.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC register, req/ack instruction fetch and next-PC update on retire.
// Optional retire counter on instr_count, built only when FETCH_RETIRE_CNT_EN is defined.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] instr_count
);

    // state | meaning
    // IDLE  | reset state, no request; leaves after one cycle
    // FETCH | request outstanding at pc, waiting for imem_ack
    // HOLD  | instr valid and executing, waiting for retire & ~stall

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] next_pc;
    logic        fetch_done;
    logic        retire_ok;

    assign fetch_done = (state == ST_FETCH) && imem_ack;
    assign retire_ok  = (state == ST_HOLD) && retire && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (retire_ok) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
        end else begin
            if (fetch_done) begin
                instr_q <= imem_rdata;
            end
            if (retire_ok) begin
                pc_q <= next_pc;
            end
        end
    end

    next_pc_sel u_next_pc_sel (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign instr_valid = (state == ST_HOLD);

`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else if (retire_ok) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, reset/jump-priority
// sequences and a randomized run against a behavioural next-PC model.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic        stall;
    logic        branch;
    logic        jump;
    logic        zero;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    typedef struct {
        logic [31:0] rdata;
        int          dly;
        int          stl;
        bit          br;
        bit          jp;
        bit          z;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl [8];

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op          (op),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retire      (retire),
        .stall       (stall),
        .branch      (branch),
        .jump        (jump),
        .zero        (zero),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef FETCH_RETIRE_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    // Next PC from the ISA rules using plain integer arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                               input bit br, input bit jp, input bit z);
        logic [31:0] p4;
        logic [15:0] imm;
        int          off;
        p4 = cur + 32'd4;
        if (jp) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (br && z) begin
            imm = ins[15:0];
            off = $signed(imm);
            return p4 + 32'(off * 4);
        end
        return p4;
    endfunction

    // Entered in a FETCH cycle; leaves in the FETCH cycle following retire.
    task automatic run_instr(input logic [31:0] rd, input int dly, input int stl,
                             input bit br, input bit jp, input bit z,
                             input logic [31:0] exp_next, input bit full);
        imem_ack = 1'b0;
        retire   = 1'b1;
        stall    = 1'b0;
        jump     = 1'b1;
        branch   = 1'b1;
        zero     = 1'b1;
        for (int i = 0; i < dly; i++) begin
            imem_rdata = $urandom;
            if (full) begin
                chk("wait_req", {31'd0, imem_req}, 32'd1);
                chk("wait_addr", imem_addr, m_pc);
                chk("wait_valid", {31'd0, instr_valid}, 32'd0);
            end
            step();
        end
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, m_pc);
        if (full) chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = rd;
        step();
        imem_rdata = ~rd;
        branch     = br;
        jump       = jp;
        zero       = z;
        retire     = 1'b1;
        stall      = (stl > 0);
        chk("hold_instr", instr, rd);
        if (full) begin
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_op", {26'd0, op}, {26'd0, rd[31:26]});
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_pc", pc, m_pc);
            chk("hold_pc_plus4", pc_plus4, m_pc + 32'd4);
        end
        for (int i = 0; i < stl; i++) begin
            step();
            chk("stall_pc", pc, m_pc);
            chk("stall_instr", instr, rd);
            if (full) begin
                chk("stall_valid", {31'd0, instr_valid}, 32'd1);
                chk("stall_req", {31'd0, imem_req}, 32'd0);
                chk("stall_cnt", instr_count, exp_cnt());
            end
        end
        stall = 1'b0;
        step();
        imem_ack = 1'b0;
        retire   = 1'b0;
        m_pc     = exp_next;
        m_cnt    = m_cnt + 32'd1;
        chk("retire_pc", pc, m_pc);
        if (full) begin
            chk("retire_valid", {31'd0, instr_valid}, 32'd0);
            chk("retire_req", {31'd0, imem_req}, 32'd1);
            chk("retire_addr", imem_addr, m_pc);
            chk("retire_cnt", instr_count, exp_cnt());
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"}, pc, RST_PC);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_cnt"}, instr_count, 32'd0);
        chk({tag, "_op"}, {26'd0, op}, 32'd0);
        chk({tag, "_pc_plus4"}, pc_plus4, RST_PC + 32'd4);
    endtask

    // Releases reset and checks the one-cycle IDLE before the first request.
    task automatic release_reset();
        rst = 1'b0;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, RST_PC);
        m_pc  = RST_PC;
        m_cnt = 32'd0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] exp;
        bit          br, jp, z;

        tbl[0] = '{32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
        tbl[1] = '{32'h0000_0020, 3, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0008};
        tbl[2] = '{32'h0800_0010, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0040};
        tbl[3] = '{32'h1000_FFFF, 0, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0040};
        tbl[4] = '{32'h1000_FFFF, 1, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0044};
        tbl[5] = '{32'h1000_FFED, 0, 5, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC};
        tbl[6] = '{32'h1234_5678, 2, 1, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
        tbl[7] = '{32'h0800_0010, 0, 2, 1'b1, 1'b1, 1'b1, 32'h0000_0040};

        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        retire     = 1'b0;
        stall      = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        zero       = 1'b0;
        m_pc       = RST_PC;
        m_cnt      = 32'd0;
        step();
        step();
        check_reset_state("reset");
        release_reset();

        for (int i = 0; i < 8; i++) begin
            run_instr(tbl[i].rdata, tbl[i].dly, tbl[i].stl, tbl[i].br, tbl[i].jp,
                      tbl[i].z, tbl[i].exp_pc, 1'b1);
            if (i == 0) chk("addi_op", {26'd0, tbl[0].rdata[31:26]}, {26'd0, OP_ADDI});
        end

        // Reset while a request is outstanding at a nonzero pc.
        step();
        step();
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b1;
        step();
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_pc", pc, RST_PC);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check_reset_state("midrst");
        release_reset();

        // Climb to 32'h1000_0000 with maximal forward branches, then jump with branch high.
        for (int i = 0; i < 2048; i++) begin
            exp = model_next(m_pc, 32'h1000_7FFF, 1'b1, 1'b0, 1'b1);
            run_instr(32'h1000_7FFF, 0, 0, 1'b1, 1'b0, 1'b1, exp, 1'b0);
        end
        chk("climb_pc", pc, 32'h1000_0000);
        run_instr(32'h0800_0010, 0, 0, 1'b1, 1'b1, 1'b1, 32'h1000_0040, 1'b1);

        for (int i = 0; i < 200; i++) begin
            rd  = $urandom;
            br  = 1'($urandom_range(0, 1));
            jp  = ($urandom_range(0, 3) == 0);
            z   = 1'($urandom_range(0, 1));
            exp = model_next(m_pc, rd, br, jp, z);
            run_instr(rd, $urandom_range(0, 3), $urandom_range(0, 2), br, jp, z, exp, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-cycle MIPS core, sitting directly upstream of the main control decoder. It owns the PC register, fetches instructions from instruction memory over a req/ack handshake, and holds the instruction stable while the decoder and datapath execute it. On retire it computes the next PC from the decoder's `branch`/`jump` outputs and the ALU `zero` flag.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: fetch address, always equal to `pc`.
- `imem_ack`  in  1: instruction memory has returned data this cycle.
- `imem_rdata`  in  32: instruction word, sampled when `imem_req & imem_ack`.
- `instr`  out  32: held instruction.
- `op`  out  6: `instr[31:26]`, drives the decoder `op` input.
- `instr_valid`  out  1: `instr` is valid and is being executed.
- `pc`  out  32: address of the current instruction.
- `pc_plus4`  out  32: `pc + 4`, modulo 2^32.
- `retire`  in  1: datapath has finished the current instruction.
- `stall`  in  1: blocks retire while high.
- `branch`, `jump`, `zero`  in  1 each: from the decoder and ALU; sampled only on an accepted retire.
- `instr_count`  out  32: number of retired instructions (see Configuration).

## Operation
- FSM states:
  - IDLE (reset state): `imem_req` = 0. Goes to FETCH unconditionally on the next cycle.
  - FETCH: `imem_req` = 1, `imem_addr` = `pc`, held stable until ack. On `imem_ack`: latch `imem_rdata` into `instr`, set `instr_valid`, go to HOLD.
  - HOLD: `instr_valid` = 1, `imem_req` = 0.
    - On `retire & ~stall`: load the next PC, clear `instr_valid`, go to FETCH.
    - Otherwise stay in HOLD.
- Next PC, in priority order:
  - `jump`: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - `branch & zero`: `pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
  - Otherwise: `pc_plus4`.
- Arithmetic is 32-bit and wraps silently: 32'hFFFF_FFFC + 4 gives 0.
- Boundary conditions:
  - `jump` and `branch` both high: jump wins.
  - `branch` with `zero` = 0: next PC is `pc_plus4`.
  - `imem_ack` outside FETCH is ignored.
  - `retire` outside HOLD is ignored.
  - `stall` held indefinitely: stays in HOLD with all outputs frozen.
- Reset mid-fetch abandons the outstanding request. Memory must tolerate a dropped request.

## Timing
- Reset values: `pc` = `RESET_PC`, `instr` = 0, `instr_valid` = 0, `imem_req` = 0, `instr_count` = 0. `op` and `pc_plus4` follow from these.
- `imem_req` is decoded from the registered state, so it is glitch-free.
- `imem_addr` is constant for the whole time `imem_req` is high.
- Zero-wait memory (ack in the first FETCH cycle): `instr_valid` rises on the next edge.
- Minimum throughput is 2 cycles per instruction: 1 FETCH + 1 HOLD.
- First `imem_req` after reset release: cycle 2 (IDLE lasts 1 cycle).
- `pc`, `instr_valid` and `instr_count` update on the same edge that accepts `retire`.
- The new `imem_req` asserts in the cycle after retire.

## Configuration
- `FETCH_RETIRE_CNT_EN` defined:
  - `instr_count` increments by 1 on every accepted retire.
  - Wraps from 32'hFFFF_FFFF to 0.
  - Cleared by `rst`.
- `FETCH_RETIRE_CNT_EN` undefined: `instr_count` is tied to 0 and the counter register is not built. The port list is unchanged.

## Structure
- Shared package/header holds:
  - FSM state encodings IDLE/FETCH/HOLD.
  - Opcode constants (R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010), shared with the decoder.
  - Default `RESET_PC`.
- One combinational sub-module, `next_pc_sel`.
  - Inputs: `pc_plus4`, `instr`, `branch`, `jump`, `zero`.
  - Output: next PC.
  - Instantiated once; keeps the FSM file free of target arithmetic.

## Test plan
- Reset, then zero-wait memory returning 32'h2008_0005 (ADDI), retire in the first HOLD cycle:
  - `imem_req` first high in cycle 2, `imem_addr` = 0.
  - `op` = 6'b001000.
  - After retire, `pc` = 4 and `instr_count` = 1.
- Memory ack delayed 3 cycles:
  - `imem_req` and `imem_addr` stay constant for 4 cycles.
  - `instr_valid` stays 0 until the edge after ack.
- BEQ 32'h1000_FFFF at `pc` = 32'h40, `branch` = 1, `zero` = 1: next `pc` = 32'h40. With `zero` = 0: next `pc` = 32'h44.
- J 32'h0800_0010 at `pc` = 32'h1000_0000 with `branch` also high: next `pc` = 32'h1000_0040 (jump priority).
- `stall` high for 5 cycles with `retire` high: `pc`, `instr` and `instr_count` frozen. They advance one cycle after `stall` falls.
- `rst` asserted while in FETCH with no ack:
  - Next cycle `imem_req` = 0, `pc` = `RESET_PC`, `instr_valid` = 0.
  - Fetch restarts at `RESET_PC` one cycle after `rst` falls.
